case_4_prod_accum: RTL and testbench



---
 rtl/case_4_prod_accum.sv | 110 +++++++++++
 tb/tb_case_4_prod_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/case_4_prod_accum.sv
// case_4_prod_accum: group accumulator for the case_4 truncated signed products.
// Optional saturation of dout on overflow: define CASE_4_PROD_ACCUM_SAT_EN.
module case_4_prod_accum #(
  parameter int DIN_WIDTH  = 6,
  parameter int ACC_LEN    = 8,
  parameter int DOUT_WIDTH = 10,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_vld,
  input  logic                         din_last,
  output logic                         din_rdy,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0]         dout_cnt,
  output logic                         dout_ovf,
  output logic                         dout_vld,
  input  logic                         dout_rdy
);

  localparam int AW = DIN_WIDTH + $clog2(ACC_LEN) + 1;
  localparam int XW = (AW > DOUT_WIDTH) ? AW : DOUT_WIDTH;
  localparam int DW = DOUT_WIDTH;

  localparam logic signed [XW-1:0] MAXV =
    {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  localparam logic [DW-1:0] MAXD = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIND = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {ACCUM, OUT} state_t;

  state_t               state;
  logic signed [AW-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic signed [AW-1:0] din_x;
  logic signed [AW-1:0] sum;
  logic signed [XW-1:0] sum_x;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 accept;
  logic                 fin;
  logic                 ovf;
  logic [DW-1:0]        wrap;
  logic [DW-1:0]        res;

  assign din_x  = AW'(din);
  assign sum    = acc + din_x;
  assign sum_x  = XW'(sum);
  assign cnt_nx = cnt + CNT_WIDTH'(1);
  assign accept = din_vld & din_rdy & (state == ACCUM);
  assign fin    = (cnt_nx == CNT_WIDTH'(ACC_LEN)) | din_last;
  assign ovf    = (sum_x > MAXV) | (sum_x < MINV);
  assign wrap   = sum_x[DW-1:0];

  // Narrow the full-precision sum to the output width.
  always_comb begin
    res = wrap;
`ifdef CASE_4_PROD_ACCUM_SAT_EN
    if (ovf) begin
      res = sum_x[XW-1] ? MIND : MAXD;
    end
`endif
  end

  // Group FSM: accumulate, then hold the registered result until taken.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      din_rdy  <= 1'b0;
      dout     <= '0;
      dout_cnt <= '0;
      dout_ovf <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (fin) begin
              state    <= OUT;
              acc      <= '0;
              cnt      <= '0;
              din_rdy  <= 1'b0;
              dout     <= res;
              dout_cnt <= cnt_nx;
              dout_ovf <= ovf;
              dout_vld <= 1'b1;
            end else begin
              acc <= sum;
              cnt <= cnt_nx;
            end
          end else begin
            din_rdy <= 1'b1;
          end
        end
        OUT: begin
          if (dout_rdy) begin
            dout_vld <= 1'b0;
            state    <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_4_prod_accum.sv
// tb_case_4_prod_accum: directed scoreboard bench, default and 6-bit output
// instances driven in lockstep from the same stimulus.
module tb_case_4_prod_accum;

  logic              clk = 1'b0;
  logic              ap_rst;
  logic signed [5:0] din;
  logic              din_vld;
  logic              din_last;
  logic              dout_rdy;

  logic              din_rdy;
  logic signed [9:0] dout;
  logic [3:0]        dout_cnt;
  logic              dout_ovf;
  logic              dout_vld;

  logic              n_rdy;
  logic signed [5:0] n_dout;
  logic [3:0]        n_cnt;
  logic              n_ovf;
  logic              n_vld;

  always #5 clk = ~clk;

  case_4_prod_accum u_dut (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_last (din_last),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_cnt (dout_cnt),
    .dout_ovf (dout_ovf),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  case_4_prod_accum #(.DOUT_WIDTH(6)) u_nar (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_last (din_last),
    .din_rdy  (n_rdy),
    .dout     (n_dout),
    .dout_cnt (n_cnt),
    .dout_ovf (n_ovf),
    .dout_vld (n_vld),
    .dout_rdy (dout_rdy)
  );

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   msum;
  int   mcnt;
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int conv(input int s, input int w);
    int mx;
    int mn;
    int m;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
`ifdef CASE_4_PROD_ACCUM_SAT_EN
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
`else
    m = s & ((1 << w) - 1);
    if (m > mx) m = m - (1 << w);
    return m;
`endif
  endfunction

  function automatic int oflow(input int s, input int w);
    int mx;
    int mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    return ((s > mx) || (s < mn)) ? 1 : 0;
  endfunction

  task automatic send(input int v, input logic last);
    int t;
    logic [31:0] vb;
    vb = v;
    @(negedge clk);
    din      = vb[5:0];
    din_vld  = 1'b1;
    din_last = last;
    t = 0;
    while (din_rdy !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy", din_rdy, 1);
    @(posedge clk);
    #1;
    din_vld  = 1'b0;
    din_last = 1'b0;
    msum += v;
    mcnt++;
    if (mcnt == 8 || last) begin
      q.push_back('{sum: msum, cnt: mcnt});
      msum = 0;
      mcnt = 0;
    end
  endtask

  task automatic group(input int v, input int n);
    for (int i = 0; i < n; i++) send(v, 1'b0);
  endtask

  task automatic get(input int hold);
    int   t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (dout_vld !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("out_vld", dout_vld, 1);
    chk("q_nonempty", q.size() > 0, 1);
    e = '{sum: 0, cnt: 0};
    if (q.size() > 0) e = q.pop_front();
    chk("dout", dout, conv(e.sum, 10));
    chk("dout_cnt", dout_cnt, e.cnt);
    chk("dout_ovf", dout_ovf, oflow(e.sum, 10));
    chk("n_dout", n_dout, conv(e.sum, 6));
    chk("n_cnt", n_cnt, e.cnt);
    chk("n_ovf", n_ovf, oflow(e.sum, 6));
    chk("out_rdy_lo", din_rdy, 0);
    if (hold > 0) begin
      din     = 6'sd7;
      din_vld = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_vld", dout_vld, 1);
        chk("hold_dout", dout, conv(e.sum, 10));
        chk("hold_cnt", dout_cnt, e.cnt);
        chk("hold_rdy", din_rdy, 0);
      end
      din_vld  = 1'b0;
      dout_rdy = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("taken_vld", dout_vld, 0);
    chk("bubble_rdy", din_rdy, 0);
    @(negedge clk);
    chk("resume_rdy", din_rdy, 1);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    msum     = 0;
    mcnt     = 0;
    ap_rst   = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    din_last = 1'b0;
    dout_rdy = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_cnt", dout_cnt, 0);
    chk("rst_ovf", dout_ovf, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_rdy", din_rdy, 0);
    ap_rst = 1'b0;
    @(negedge clk);
    chk("rel_rdy", din_rdy, 1);

    dout_rdy = 1'b1;
    group(5, 8);
    get(0);

    group(-32, 8);
    get(0);

    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b1);
    get(0);
    group(-1, 8);
    get(0);

    group(31, 8);
    get(0);

    dout_rdy = 1'b0;
    group(2, 8);
    get(5);

    send(-7, 1'b1);
    get(0);

    group(4, 7);
    send(4, 1'b1);
    get(0);
    @(negedge clk);
    chk("single_end", dout_vld, 0);

    group(3, 4);
    @(negedge clk);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_cnt", dout_cnt, 0);
    chk("arst_vld", dout_vld, 0);
    chk("arst_rdy", din_rdy, 0);
    msum = 0;
    mcnt = 0;
    @(negedge clk);
    ap_rst = 1'b0;
    group(2, 8);
    get(0);

    chk("q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
